// File: rtl/serial_deser_pkg.sv
// Shared definitions for the framed serial deserializer: FSM state encoding and default sizing.
package serial_deser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 3;

endpackage

// File: rtl/deser_out_reg.sv
// Output holding register for serial_deser: word/valid/overrun with a valid/ready handshake.
// Macro DESER_PARITY_EN adds the registered parity-error flag that travels with the word.
module deser_out_reg #(
  parameter int WIDTH = serial_deser_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
`ifdef DESER_PARITY_EN
  input  logic             perr_i,
  output logic             q_perr_o,
`endif
  input  logic             q_ready_i,
  input  logic             clear_ovr_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
`ifdef DESER_PARITY_EN
  logic             perr_q, perr_d;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    q_d     = q_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
`ifdef DESER_PARITY_EN
    perr_d  = perr_q;
`endif
    if (clear_ovr_i) ovr_d = 1'b0;
    if (load_i) begin
      // A slot frees up on this edge if it was empty or is being accepted right now.
      if (!valid_q || q_ready_i) begin
        q_d     = word_i;
        valid_d = 1'b1;
`ifdef DESER_PARITY_EN
        perr_d  = perr_i;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && q_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      q_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef DESER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef DESER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign q_o       = q_q;
  assign q_valid_o = valid_q;
  assign overrun_o = ovr_q;
`ifdef DESER_PARITY_EN
  assign q_perr_o  = perr_q;
`endif

endmodule

// File: rtl/serial_deser.sv
// Framed serial-to-parallel deserializer: start bit, WIDTH data bits MSB-first, valid/ready output.
// Macro DESER_PARITY_EN adds a trailing even-parity bit and the Q_perr output.
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             A,
  input  logic             A_valid,
  input  logic             Q_ready,
  input  logic             Clear_ovr,
  output logic [WIDTH-1:0] Q,
  output logic             Q_valid,
  output logic             Busy,
`ifdef DESER_PARITY_EN
  output logic             Q_perr,
`endif
  output logic             Overrun
);

  // Without parity the last data bit completes the word straight from the input,
  // so the shifter only needs to hold the first WIDTH-1 bits.
`ifdef DESER_PARITY_EN
  localparam int SHIFT_W = WIDTH;
`else
  localparam int SHIFT_W = WIDTH - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               load;
  logic [WIDTH-1:0]   word;
`ifdef DESER_PARITY_EN
  logic               perr;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    load    = 1'b0;
`ifdef DESER_PARITY_EN
    word    = shift_q;
    perr    = 1'b0;
`else
    word    = {shift_q, A};
`endif
    if (A_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (A) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          shift_d = SHIFT_W'({shift_q, A});
          if (cnt_q == LAST_BIT) begin
`ifdef DESER_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_IDLE;
            load    = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef DESER_PARITY_EN
        ST_PAR: begin
          state_d = ST_IDLE;
          load    = 1'b1;
          perr    = (^shift_q) ^ A;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign Busy = (state_q != ST_IDLE);

  deser_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk         (Clock),
    .rst_n       (Resetn),
    .load_i      (load),
    .word_i      (word),
`ifdef DESER_PARITY_EN
    .perr_i      (perr),
    .q_perr_o    (Q_perr),
`endif
    .q_ready_i   (Q_ready),
    .clear_ovr_i (Clear_ovr),
    .q_o         (Q),
    .q_valid_o   (Q_valid),
    .overrun_o   (Overrun)
  );

endmodule

// File: tb/tb_serial_deser.sv
// Directed self-checking bench for serial_deser (8-bit frames); parity steps run when DESER_PARITY_EN is defined.
module tb_serial_deser;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       a         = 1'b0;
  logic       a_valid   = 1'b0;
  logic       q_ready   = 1'b0;
  logic       clear_ovr = 1'b0;
  logic [7:0] q;
  logic       q_valid;
  logic       busy;
  logic       overrun;
`ifdef DESER_PARITY_EN
  logic       q_perr;
`endif

  int errors     = 0;
  int checks     = 0;
  int busy_drops = 0;

  always #5 clk = ~clk;

  serial_deser #(
    .WIDTH (8),
    .CNT_W (3)
  ) dut (
    .Clock     (clk),
    .Resetn    (rst_n),
    .A         (a),
    .A_valid   (a_valid),
    .Q_ready   (q_ready),
    .Clear_ovr (clear_ovr),
    .Q         (q),
    .Q_valid   (q_valid),
    .Busy      (busy),
`ifdef DESER_PARITY_EN
    .Q_perr    (q_perr),
`endif
    .Overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one bit, let one rising edge pass, then settle 1 ns for sampling.
  task automatic send_bit(input logic v, input logic b);
    a_valid = v;
    a       = b;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a       = 1'b0;
  endtask

  // Start bit plus the first nbits data bits MSB-first, with gap idle edges before each data bit.
  task automatic send_frame(input logic [7:0] w, input int gap, input int nbits);
    send_bit(1'b1, 1'b1);
    if (!busy) busy_drops++;
    for (int i = 0; i < nbits; i++) begin
      repeat (gap) begin
        send_bit(1'b0, 1'b0);
        if (!busy) busy_drops++;
      end
      send_bit(1'b1, w[7-i]);
      if (i < 7 && !busy) busy_drops++;
    end
  endtask

  // Last data bit, plus the parity bit when the parity build is active.
  task automatic complete(input logic last, input logic par);
    send_bit(1'b1, last);
`ifdef DESER_PARITY_EN
    send_bit(1'b1, par);
`else
    if (par) begin end
`endif
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset holds everything low whatever the stimulus; A=0 ignored after release
    q_ready = 1'b1;
    repeat (3) send_bit(1'b1, 1'b1);
    check("rst_q", 32'(q), 32'h00);
    check("rst_q_valid", 32'(q_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_q_valid", 32'(q_valid), 32'd0);

    // 2a: back-to-back bits, Q_ready=1 -> 0xA5, valid for exactly one edge
    send_frame(8'hA5, 0, 7);
    check("a5_pre_valid", 32'(q_valid), 32'd0);
    check("a5_pre_busy", 32'(busy), 32'd1);
    complete(1'b1, 1'b0);
    check("a5_q", 32'(q), 32'hA5);
    check("a5_valid", 32'(q_valid), 32'd1);
    check("a5_busy_done", 32'(busy), 32'd0);
    send_bit(1'b0, 1'b0);
    check("a5_drain_valid", 32'(q_valid), 32'd0);
    check("a5_drain_q", 32'(q), 32'hA5);

    // 2b: A_valid every third cycle, Busy must stay high across the gaps
    busy_drops = 0;
    send_frame(8'hA5, 2, 7);
    repeat (2) begin
      send_bit(1'b0, 1'b0);
      if (!busy) busy_drops++;
    end
    check("slow_busy_drops", 32'(busy_drops), 32'd0);
    check("slow_pre_valid", 32'(q_valid), 32'd0);
    complete(1'b1, 1'b0);
    check("slow_q", 32'(q), 32'hA5);
    check("slow_valid", 32'(q_valid), 32'd1);
    send_bit(1'b0, 1'b0);
    check("slow_drain_valid", 32'(q_valid), 32'd0);

    // 3: output blocked -> second word dropped, Overrun sticky, then cleared
    q_ready = 1'b0;
    send_frame(8'hA5, 0, 7);
    complete(1'b1, 1'b0);
    check("blk_first_q", 32'(q), 32'hA5);
    send_frame(8'h3C, 0, 7);
    complete(1'b0, 1'b0);
    check("blk_q_held", 32'(q), 32'hA5);
    check("blk_valid", 32'(q_valid), 32'd1);
    check("blk_overrun", 32'(overrun), 32'd1);
    clear_ovr = 1'b1;
    send_bit(1'b0, 1'b0);
    clear_ovr = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);
    send_frame(8'h5A, 0, 7);
    clear_ovr = 1'b1;
    complete(1'b0, 1'b0);
    clear_ovr = 1'b0;
    check("set_wins_overrun", 32'(overrun), 32'd1);
    check("set_wins_q", 32'(q), 32'hA5);
    clear_ovr = 1'b1;
    send_bit(1'b0, 1'b0);
    clear_ovr = 1'b0;
    check("clr2_overrun", 32'(overrun), 32'd0);

    // 4: accept pending 0xA5 on the 0x3C completion edge -> replace, no overrun
    send_frame(8'h3C, 0, 7);
    q_ready = 1'b1;
    complete(1'b0, 1'b0);
    check("swap_q", 32'(q), 32'h3C);
    check("swap_valid", 32'(q_valid), 32'd1);
    check("swap_overrun", 32'(overrun), 32'd0);
    send_bit(1'b0, 1'b0);
    check("swap_drain_valid", 32'(q_valid), 32'd0);
    check("swap_drain_q", 32'(q), 32'h3C);

    // 5: reset mid-frame discards partial word; next frame intact
    send_frame(8'h5A, 0, 4);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_q", 32'(q), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h5A, 0, 7);
    check("post_rst_no_valid", 32'(q_valid), 32'd0);
    complete(1'b0, 1'b0);
    check("post_rst_q", 32'(q), 32'h5A);
    check("post_rst_valid", 32'(q_valid), 32'd1);
    send_bit(1'b0, 1'b0);

`ifdef DESER_PARITY_EN
    // 6: even parity over data + parity bit; Q_valid after 10th edge
    send_frame(8'hA5, 0, 7);
    send_bit(1'b1, 1'b1);
    check("par_after9_valid", 32'(q_valid), 32'd0);
    check("par_after9_busy", 32'(busy), 32'd1);
    send_bit(1'b1, 1'b0);
    check("par_ok_q", 32'(q), 32'hA5);
    check("par_ok_valid", 32'(q_valid), 32'd1);
    check("par_ok_perr", 32'(q_perr), 32'd0);
    send_bit(1'b0, 1'b0);
    send_frame(8'hA5, 0, 7);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    check("par_bad_perr", 32'(q_perr), 32'd1);
    check("par_bad_valid", 32'(q_valid), 32'd1);
    send_bit(1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
